// File: rtl/bus_arbiter_if.sv
// Arbitration handshake between the DMA channels / CPU sequencer and the
// bus arbiter. The requesters use the master modport; the arbiter uses the
// slave modport.
interface bus_arbiter_if;
  logic [3:0] dma_req;
  logic [3:0] dma_unit_done;
  logic [3:0] dma_done;
  logic       cpu_preemptable;
  logic       bus_pause;
  logic [3:0] dma_grant;
  logic       dma_active;
  logic [2:0] owner;
  logic [7:0] run_cnt;

  modport master (
    output dma_req,
    output dma_unit_done,
    output dma_done,
    output cpu_preemptable,
    output bus_pause,
    input  dma_grant,
    input  dma_active,
    input  owner,
    input  run_cnt
  );

  modport slave (
    input  dma_req,
    input  dma_unit_done,
    input  dma_done,
    input  cpu_preemptable,
    input  bus_pause,
    output dma_grant,
    output dma_active,
    output owner,
    output run_cnt
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shared system bus arbiter: the CPU owns the bus by default. The four DMA
// channels win it by fixed priority (channel 0 highest), and ownership
// changes only at safe switch points. dma_active is the CPU stall and
// bus-mux select.
module bus_arbiter #(
  parameter int unsigned MAX_RUN      = 0,
  parameter int unsigned CPU_MIN_SLOT = 1
) (
  input  logic         clock,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    CPU_OWN,
    HANDOFF_IN,
    DMA_RUN,
    HANDOFF_OUT
  } state_t;

  localparam logic [3:0] SLOT_LOAD = CPU_MIN_SLOT[3:0];
  localparam logic [8:0] RUN_LIMIT = MAX_RUN[8:0];

  state_t     state_q, state_d;
  logic [1:0] cur_q, cur_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic [3:0] slot_q, slot_d;
  logic [3:0] grant_q, grant_d;
  logic       active_q, active_d;
  logic [2:0] owner_q, owner_d;
  logic       pend_done_q, pend_done_d;
  logic       pend_unit_q, pend_unit_d;

  logic [3:0] cur_mask;
  logic [3:0] others;
  logic [3:0] lower_req;
  logic       done_eff;
  logic       unit_eff;
  logic       run_limit;
  logic [7:0] run_inc;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Next-state, counter and registered-output computation.
  always_comb begin
    cur_mask  = 4'b0001 << cur_q;
    others    = bus.dma_req & ~cur_mask;
    lower_req = bus.dma_req & (cur_mask - 4'd1);
    done_eff  = pend_done_q | (|(bus.dma_done & cur_mask));
    unit_eff  = pend_unit_q | (|(bus.dma_unit_done & cur_mask));
    run_limit = (MAX_RUN != 0) && (({1'b0, run_cnt_q} + 9'd1) == RUN_LIMIT);
    run_inc   = (run_cnt_q == 8'hFF) ? run_cnt_q : run_cnt_q + 8'd1;

    state_d     = state_q;
    cur_d       = cur_q;
    run_cnt_d   = run_cnt_q;
    slot_d      = slot_q;
    pend_done_d = 1'b0;
    pend_unit_d = 1'b0;

    if (bus.bus_pause) begin
      // Frozen: remember pulses on the current channel so they apply at the
      // first unpaused edge.
      if (state_q == DMA_RUN) begin
        pend_done_d = done_eff;
        pend_unit_d = unit_eff;
      end
    end else begin
      case (state_q)
        CPU_OWN: begin
          if (slot_q != '0) slot_d = slot_q - 4'd1;
          // The counter hits 0 on the edge that leaves, so a load of N
          // gives exactly N cycles in CPU_OWN.
          if ((|bus.dma_req) && bus.cpu_preemptable && (slot_q <= 4'd1)) begin
            state_d = HANDOFF_IN;
            cur_d   = lowest(bus.dma_req);
          end
        end
        HANDOFF_IN: begin
          state_d   = DMA_RUN;
          run_cnt_d = '0;
        end
        DMA_RUN: begin
          if (done_eff || !(|(bus.dma_req & cur_mask))) begin
            if (|others) begin
              state_d = HANDOFF_IN;
              cur_d   = lowest(others);
            end else begin
              state_d = HANDOFF_OUT;
            end
          end else if (unit_eff && (|lower_req)) begin
            state_d = HANDOFF_IN;
            cur_d   = lowest(lower_req);
          end else if (unit_eff && run_limit) begin
            state_d   = HANDOFF_OUT;
            slot_d    = SLOT_LOAD;
            run_cnt_d = run_inc;
          end else if (unit_eff) begin
            run_cnt_d = run_inc;
          end
        end
        HANDOFF_OUT: state_d = CPU_OWN;
        default:     state_d = CPU_OWN;
      endcase
    end

    grant_d  = (state_d == DMA_RUN) ? (4'b0001 << cur_d) : '0;
    active_d = (state_d != CPU_OWN);
    owner_d  = active_d ? {1'b0, cur_d} : 3'd4;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CPU_OWN;
      cur_q       <= '0;
      run_cnt_q   <= '0;
      slot_q      <= '0;
      grant_q     <= '0;
      active_q    <= 1'b0;
      owner_q     <= 3'd4;
      pend_done_q <= 1'b0;
      pend_unit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      run_cnt_q   <= run_cnt_d;
      slot_q      <= slot_d;
      grant_q     <= grant_d;
      active_q    <= active_d;
      owner_q     <= owner_d;
      pend_done_q <= pend_done_d;
      pend_unit_q <= pend_unit_d;
    end
  end

  assign bus.dma_grant  = grant_q;
  assign bus.dma_active = active_q;
  assign bus.owner      = owner_q;
  assign bus.run_cnt    = run_cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: one default instance and one with MAX_RUN=4,
// CPU_MIN_SLOT=3, both driven by the same stimulus.
module tb_bus_arbiter;

  localparam int X = -1;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req, unit, done;
  logic       pre, pause;
  logic       sel;
  int         checks = 0;
  int         errors = 0;

  bus_arbiter_if bus0();
  bus_arbiter_if bus1();

  assign bus0.dma_req         = req;
  assign bus0.dma_unit_done   = unit;
  assign bus0.dma_done        = done;
  assign bus0.cpu_preemptable = pre;
  assign bus0.bus_pause       = pause;
  assign bus1.dma_req         = req;
  assign bus1.dma_unit_done   = unit;
  assign bus1.dma_done        = done;
  assign bus1.cpu_preemptable = pre;
  assign bus1.bus_pause       = pause;

  bus_arbiter u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  bus_arbiter #(
    .MAX_RUN      (4),
    .CPU_MIN_SLOT (3)
  ) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] unit;
    logic [3:0] done;
    logic       pre;
    logic       pause;
    int         g;
    int         a;
    int         o;
    int         r;
  } vec_t;

  typedef struct {
    int row;
    int g;
    int a;
    int o;
    int r;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] un,
                              input logic [3:0] dn, input logic pr, input logic pa,
                              input int g, input int a, input int o, input int r);
    vec_t v;
    v.rst = rst; v.req = rq; v.unit = un; v.done = dn; v.pre = pr; v.pause = pa;
    v.g = g; v.a = a; v.o = o; v.r = r;
    return v;
  endfunction

  task automatic check(input string name, input int row, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        errors++;
        $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
      end
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("grant",   e.row, sel ? int'(bus1.dma_grant)  : int'(bus0.dma_grant),  e.g);
      check("active",  e.row, sel ? int'(bus1.dma_active) : int'(bus0.dma_active), e.a);
      check("owner",   e.row, sel ? int'(bus1.owner)      : int'(bus0.owner),      e.o);
      check("run_cnt", e.row, sel ? int'(bus1.run_cnt)    : int'(bus0.run_cnt),    e.r);
    end
  endtask

  task automatic step(input vec_t v, input int row);
    exp_t e;
    reset = v.rst; req = v.req; unit = v.unit; done = v.done; pre = v.pre; pause = v.pause;
    e.row = row; e.g = v.g; e.a = v.a; e.o = v.o; e.r = v.r;
    sb.push_back(e);
    @(posedge clock);
    #1;
    compare_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_cpu;
    bit  got;
    sel = 1'b0;
    reset = 1'b1; req = '0; unit = '0; done = '0; pre = 1'b0; pause = 1'b0;

    //          rst req   unit  done  pre pau  grant act own run
    // Reset state and single request on channel 0
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0,  0, 0, 4, 0));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 1, 0,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 1, 0,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h1, 4'h1, 4'h0, 1, 0,  1, 1, 0, 1));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 1, 0,  1, 1, 0, 1));
    tbl.push_back(mk(0, 4'h1, 4'h1, 4'h0, 1, 0,  1, 1, 0, 2));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 1, 0,  1, 1, 0, 2));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 1, 0,  1, 1, 0, 2));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 4, X));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 4, X));
    // Priority and preemption: ch2 running, ch0 arrives
    tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 1, 0,  4, 1, 2, 0));
    tbl.push_back(mk(0, 4'h5, 4'h0, 4'h0, 1, 0,  4, 1, 2, 0));
    tbl.push_back(mk(0, 4'h5, 4'h4, 4'h0, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h5, 4'h0, 4'h0, 1, 0,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h5, 4'h1, 4'h0, 1, 0,  1, 1, 0, 1));
    tbl.push_back(mk(0, 4'h5, 4'h0, 4'h1, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 1, 0,  4, 1, 2, 0));
    tbl.push_back(mk(0, 4'h4, 4'h1, 4'h0, 1, 0,  4, 1, 2, 0));
    tbl.push_back(mk(0, 4'h4, 4'h0, 4'h1, 1, 0,  4, 1, 2, 0));
    tbl.push_back(mk(0, 4'h4, 4'h0, 4'h4, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 4, X));
    // Release by dropping the request without a done pulse
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 1, 0,  2, 1, 1, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 4, X));
    // Gating: pause in CPU_OWN, then not preemptable
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 1, 1,  0, 0, 4, X));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 0, 0,  0, 0, 4, X));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 0, 0,  0, 0, 4, X));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 0, 0,  0, 0, 4, X));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 0, 0,  0, 0, 4, X));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 0, 0,  0, 0, 4, X));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 0, 0,  8, 1, 3, 0));
    // Done pulse during pause is held until the pause drops
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h8, 0, 1,  8, 1, 3, 0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 0, 1,  8, 1, 3, 0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 0, 1,  8, 1, 3, 0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 0, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0,  0, 0, 4, X));
    // Simultaneous done + unit_done on cur: done wins, lowest pending next
    tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 1, 0,  4, 1, 2, 0));
    tbl.push_back(mk(0, 4'h7, 4'h4, 4'h4, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 1, 0,  1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h1, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 1, 0,  2, 1, 1, 0));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h2, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 4, X));
    // Done + unit_done with only a lower-priority request pending
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 1, 0,  2, 1, 1, 0));
    tbl.push_back(mk(0, 4'hA, 4'h2, 4'h2, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h0, 1, 0,  8, 1, 3, 0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 4'h8, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 4, X));
    // Reset in the middle of a DMA_RUN grant
    tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 1, 0,  0, 1, X, X));
    tbl.push_back(mk(0, 4'h4, 4'h0, 4'h0, 1, 0,  4, 1, 2, 0));
    tbl.push_back(mk(0, 4'h4, 4'h4, 4'h0, 1, 0,  4, 1, 2, 1));
    tbl.push_back(mk(1, 4'h4, 4'h4, 4'h0, 1, 0,  0, 0, 4, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0,  0, 0, 4, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // MAX_RUN=4 / CPU_MIN_SLOT=3 instance: ch1 streams a unit every 2 cycles
    sel = 1'b1;
    step(mk(1, 4'h0, 4'h0, 4'h0, 0, 0,  0, 0, 4, 0), 1000);
    step(mk(0, 4'h2, 4'h0, 4'h0, 1, 0,  0, 1, X, X), 1001);
    step(mk(0, 4'h2, 4'h0, 4'h0, 1, 0,  2, 1, 1, 0), 1002);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        step(mk(0, 4'h2, 4'h2, 4'h0, 1, 0,  2, 1, 1, k + 1), 1010 + 2 * k);
        step(mk(0, 4'h2, 4'h0, 4'h0, 1, 0,  2, 1, 1, k + 1), 1011 + 2 * k);
      end else begin
        step(mk(0, 4'h2, 4'h2, 4'h0, 1, 0,  0, 1, X, X), 1010 + 2 * k);
      end
    end

    // Bounded wait for the regrant, counting CPU_OWN cycles on the way
    n_cpu = 0;
    got   = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      reset = 1'b0; req = 4'h2; unit = '0; done = '0; pre = 1'b1; pause = 1'b0;
      @(posedge clock);
      #1;
      if (bus1.dma_grant == 4'b0010) got = 1'b1;
      else if (!bus1.dma_active) n_cpu++;
    end
    check("regrant_seen", 1100, int'(got), 1);
    check("cpu_slot_cycles", 1101, n_cpu, 3);
    check("regrant_owner", 1102, int'(bus1.owner), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Owns the shared system bus (addr/wdata/size/write) between the CPU and the four DMA channels.
- The CPU is the default owner.
- DMA channels request the bus and are granted it by fixed priority (channel 0 highest), only at safe switch points.
- Its dma_active output is the CPU stall and bus-mux select in gba_top; it replaces direct DMA self-grant.

Parameters:
MAX_RUN, 0, max DMA transfer units per grant before the CPU is forced a slot; 0 = unlimited
CPU_MIN_SLOT, 1, minimum cycles in CPU_OWN after a forced MAX_RUN release (1..15)

Ports:
clock  input  1  gba_clk domain
reset  input  1  synchronous, active-high
dma_req  input  4  channel i wants the bus; held high until dma_done[i]
dma_unit_done  input  4  1-cycle pulse: channel i finished one read+write unit (safe switch point)
dma_done  input  4  1-cycle pulse: channel i block complete, releases bus
cpu_preemptable  input  1  CPU at an instruction boundary that may be stalled
bus_pause  input  1  memory wait; no ownership change while high
dma_grant  output  4  one-hot grant, registered
dma_active  output  1  high whenever state != CPU_OWN, registered
owner  output  3  0..3 = DMA channel, 4 = CPU, registered
run_cnt  output  8  units completed in the current grant (debug)

Behaviour:
- Reset (synchronous, any state, mid-transfer included): state = CPU_OWN; dma_grant = 0; dma_active = 0; owner = 4; run_cnt = 0; slot counter = 0. Takes effect on the same edge.
- States:
  - CPU_OWN: CPU owns the bus.
  - HANDOFF_IN: 1-cycle turnaround; dma_active = 1, dma_grant = 0.
  - DMA_RUN: dma_grant = onehot(cur).
  - HANDOFF_OUT: 1-cycle turnaround; dma_active = 1, dma_grant = 0.
- bus_pause high: state, cur, counters and all outputs frozen. Pulses arriving while paused are still sampled: dma_done / unit_done on cur take effect at the first unpaused edge (latched one deep).
- CPU_OWN -> HANDOFF_IN: requires |dma_req, cpu_preemptable = 1, bus_pause = 0 and slot counter = 0. On entry, cur = lowest index with dma_req set.
- HANDOFF_IN -> DMA_RUN: unconditional next cycle. run_cnt cleared. Grant-from-request latency is 2 edges.
- DMA_RUN, evaluated in this priority order:
  1. dma_done[cur], or dma_req[cur] low (protocol release): if another request is pending, go to HANDOFF_IN with the new lowest-index winner (dma_active stays 1). Otherwise go to HANDOFF_OUT.
  2. dma_unit_done[cur] with a pending request at index < cur: preempt. Go to HANDOFF_IN with the new winner. The preempted channel keeps its request and is regranted later.
  3. dma_unit_done[cur] with MAX_RUN != 0 and run_cnt + 1 == MAX_RUN: go to HANDOFF_OUT and load slot counter = CPU_MIN_SLOT.
  4. dma_unit_done[cur] otherwise: run_cnt += 1, saturating at 255.
- Same-cycle dma_done and dma_unit_done on cur: done wins.
- dma_done / unit_done on a non-cur channel: ignored.
- HANDOFF_OUT -> CPU_OWN: next cycle; owner = 4, dma_active = 0.
- Slot counter decrements by 1 per CPU_OWN cycle; it blocks regrant until 0.
- Requests arriving during any handoff are evaluated at the next decision point.

Test Plan:
- Single request: dma_req = 0001 with preemptable = 1 at cycle 0 -> dma_active = 1 at edge 1, dma_grant = 0001 and owner = 0 at edge 2. dma_done at cycle 10 -> dma_active = 0, owner = 4 by edge 12.
- Priority and preempt: ch2 granted, dma_req = 0101, ch2 unit_done -> HANDOFF_IN, then grant = 0001. ch0 done -> grant returns to 0100 with dma_active held high throughout.
- Gating: dma_req = 1000 with cpu_preemptable = 0 for 5 cycles -> no grant. With bus_pause = 1 in DMA_RUN plus a done pulse -> grant held until pause drops, then release.
- MAX_RUN = 4, CPU_MIN_SLOT = 3, ch1 streaming unit_done every 2 cycles -> release after the 4th unit; CPU_OWN holds exactly 3 cycles; then regrant of 0010.
- Simultaneous dma_done and dma_unit_done on cur, with a higher request pending -> treated as done; the next winner is the lowest pending index.
- Reset asserted in DMA_RUN with grant = 0100 -> next edge: grant = 0, owner = 4, dma_active = 0, run_cnt = 0.
